// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the ordered memory-command router.
// The command message is modelled as a 128-bit bp_cce_mem_msg_s:
//   [127:64] data, [63:40] remaining header fields, [39:0] header.addr.
package bp_me_pkg;

  typedef enum logic [0:0] {
    e_bp_softcore_cfg = 1'b0
  } bp_cfg_e;

  localparam int bp_paddr_width_gp        = 40;
  localparam int bp_cce_mem_msg_width_gp  = 128;
  localparam int bp_msg_addr_lsb_gp       = 0;

  typedef struct packed {
    logic [bp_paddr_width_gp-1:0] base;
    logic [bp_paddr_width_gp-1:0] mask;
  } route_entry_s;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pull header.addr out of a flat command message.
  function automatic logic [bp_paddr_width_gp-1:0] msg_addr(
    input logic [bp_cce_mem_msg_width_gp-1:0] msg);
    return msg[bp_msg_addr_lsb_gp +: bp_paddr_width_gp];
  endfunction

endpackage

// File: rtl/bp_me_order_fifo_async.sv
// Order FIFO recording the target index of each accepted command.
// Caller never enqueues when full or dequeues when empty.
module bp_me_order_fifo_async
  import bp_me_pkg::*;
#(
  parameter int depth_p = 4,
  parameter int width_p = 1,
  localparam int ptr_w_lp = idx_width(depth_p),
  localparam int cnt_w_lp = $clog2(depth_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enq_v_i,
  input  logic [width_p-1:0]  enq_data_i,
  input  logic                deq_i,
  output logic [width_p-1:0]  head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  r_mem [depth_p];
  logic [ptr_w_lp-1:0] r_wr_ptr;
  logic [ptr_w_lp-1:0] r_rd_ptr;
  logic [cnt_w_lp-1:0] r_count;

  function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(depth_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  // Pointers and occupancy; enqueue and dequeue together leave the count alone.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (enq_v_i) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (deq_i)   r_rd_ptr <= ptr_next(r_rd_ptr);
      if (enq_v_i && !deq_i)      r_count <= r_count + cnt_w_lp'(1);
      else if (!enq_v_i && deq_i) r_count <= r_count - cnt_w_lp'(1);
    end
  end

  // Entry storage is data only and needs no reset.
  always_ff @(posedge clk_i) begin
    if (enq_v_i) r_mem[r_wr_ptr] <= enq_data_i;
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign full_o  = (r_count == cnt_w_lp'(depth_p));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

endmodule

// File: rtl/bp_me_cmd_router_ordered.sv
// Routes master commands to N targets by address range and returns
// responses strictly in issue order, with a sticky head-response timeout.
module bp_me_cmd_router_ordered
  import bp_me_pkg::*;
#(
  parameter bp_cfg_e bp_params_p   = e_bp_softcore_cfg,
  parameter int num_targets_p      = 2,
  parameter int max_outstanding_p  = 4,
  parameter int default_target_p   = 1,
  parameter int timeout_cycles_p   = 1024,
  localparam int paddr_width_p        = bp_paddr_width_gp,
  localparam int cce_mem_msg_width_lp = bp_cce_mem_msg_width_gp,
  localparam int sel_w_lp             = idx_width(num_targets_p),
  localparam int cnt_w_lp             = $clog2(max_outstanding_p + 1)
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic [num_targets_p*paddr_width_p-1:0]     route_base_i,
  input  logic [num_targets_p*paddr_width_p-1:0]     route_mask_i,
  input  logic [cce_mem_msg_width_lp-1:0]            mem_cmd_i,
  input  logic                                       mem_cmd_v_i,
  output logic                                       mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0]            mem_resp_o,
  output logic                                       mem_resp_v_o,
  input  logic                                       mem_resp_ready_i,
  output logic [cce_mem_msg_width_lp-1:0]            tgt_cmd_o,
  output logic [num_targets_p-1:0]                   tgt_cmd_v_o,
  input  logic [num_targets_p-1:0]                   tgt_cmd_ready_i,
  input  logic [num_targets_p*cce_mem_msg_width_lp-1:0] tgt_resp_i,
  input  logic [num_targets_p-1:0]                   tgt_resp_v_i,
  output logic [num_targets_p-1:0]                   tgt_resp_yumi_o,
  output logic [cnt_w_lp-1:0]                        outstanding_o,
  output logic                                       timeout_o
);

  route_entry_s                    w_route [num_targets_p];
  logic [cce_mem_msg_width_lp-1:0] w_resp  [num_targets_p];
  logic [paddr_width_p-1:0]        w_addr;
  logic [sel_w_lp-1:0]             w_sel;
  logic [sel_w_lp-1:0]             w_head;
  logic                            w_full, w_empty, w_run;
  logic                            w_accept, w_deq;

  assign w_addr = msg_addr(mem_cmd_i);
  assign w_run  = ~reset_i;

  // Address decode: lowest matching index wins, otherwise the default target.
  always_comb begin
    w_sel = sel_w_lp'(default_target_p);
    for (int i = num_targets_p - 1; i >= 0; i--) begin
      w_route[i].base = route_base_i[i*paddr_width_p +: paddr_width_p];
      w_route[i].mask = route_mask_i[i*paddr_width_p +: paddr_width_p];
      w_resp[i]       = tgt_resp_i[i*cce_mem_msg_width_lp +: cce_mem_msg_width_lp];
      if ((w_addr & w_route[i].mask) == (w_route[i].base & w_route[i].mask))
        w_sel = sel_w_lp'(i);
    end
  end

  // Zero-latency command steering and in-order response selection.
  always_comb begin
    tgt_cmd_v_o            = '0;
    tgt_cmd_v_o[w_sel]     = mem_cmd_v_i & ~w_full & w_run;
    mem_cmd_ready_o        = tgt_cmd_ready_i[w_sel] & ~w_full & w_run;
    mem_resp_v_o           = ~w_empty & tgt_resp_v_i[w_head] & w_run;
    tgt_resp_yumi_o        = '0;
    tgt_resp_yumi_o[w_head] = mem_resp_v_o & mem_resp_ready_i;
  end

  assign tgt_cmd_o  = mem_cmd_i;
  assign mem_resp_o = w_resp[w_head];
  assign w_accept   = mem_cmd_v_i & mem_cmd_ready_o;
  assign w_deq      = mem_resp_v_o & mem_resp_ready_i;

  bp_me_order_fifo_async #(
    .depth_p (max_outstanding_p),
    .width_p (sel_w_lp)
  ) u_order_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .enq_v_i    (w_accept),
    .enq_data_i (w_sel),
    .deq_i      (w_deq),
    .head_o     (w_head),
    .full_o     (w_full),
    .empty_o    (w_empty),
    .count_o    (outstanding_o)
  );

  if (timeout_cycles_p > 0) begin : g_timeout
    localparam int to_w_lp = $clog2(timeout_cycles_p + 1);
    logic [to_w_lp-1:0] r_to_cnt;
    logic               r_timeout;

    // Count stalled head cycles; the flag latches when the limit is reached.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_to_cnt  <= '0;
        r_timeout <= 1'b0;
      end else begin
        if (w_empty || w_deq)
          r_to_cnt <= '0;
        else if (r_to_cnt != to_w_lp'(timeout_cycles_p))
          r_to_cnt <= r_to_cnt + to_w_lp'(1);
        if (!w_empty && !w_deq && (r_to_cnt == to_w_lp'(timeout_cycles_p - 1)))
          r_timeout <= 1'b1;
      end
    end
    assign timeout_o = r_timeout;
  end else begin : g_no_timeout
    assign timeout_o = 1'b0;
  end

`ifndef SYNTHESIS
  logic [cnt_w_lp-1:0] r_dbg_cnt [num_targets_p];

  // Shadow per-target outstanding counts for protocol checking.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_targets_p; i++) r_dbg_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < num_targets_p; i++) begin
        if (w_accept && (int'(w_sel) == i) && !(w_deq && (int'(w_head) == i)))
          r_dbg_cnt[i] <= r_dbg_cnt[i] + cnt_w_lp'(1);
        else if (w_deq && (int'(w_head) == i) && !(w_accept && (int'(w_sel) == i)))
          r_dbg_cnt[i] <= r_dbg_cnt[i] - cnt_w_lp'(1);
      end
    end
  end

  // A target with nothing outstanding must not present a response.
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (int'(w_sel) < num_targets_p);
      for (int i = 0; i < num_targets_p; i++)
        assert (!(tgt_resp_v_i[i] && (r_dbg_cnt[i] == '0)));
    end
  end
`endif

endmodule

// File: tb/tb_bp_me_cmd_router_ordered.sv
// Directed bench for the ordered command router with a response scoreboard.
module tb_bp_me_cmd_router_ordered;

  localparam int NT = 2;
  localparam int AW = 40;
  localparam int MW = 128;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [NT*AW-1:0]  route_base_i;
  logic [NT*AW-1:0]  route_mask_i;
  logic [MW-1:0]     mem_cmd_i;
  logic              mem_cmd_v_i;
  logic              mem_cmd_ready_o;
  logic [MW-1:0]     mem_resp_o;
  logic              mem_resp_v_o;
  logic              mem_resp_ready_i;
  logic [MW-1:0]     tgt_cmd_o;
  logic [NT-1:0]     tgt_cmd_v_o;
  logic [NT-1:0]     tgt_cmd_ready_i;
  logic [NT*MW-1:0]  tgt_resp_i;
  logic [NT-1:0]     tgt_resp_v_i;
  logic [NT-1:0]     tgt_resp_yumi_o;
  logic [2:0]        outstanding_o;
  logic              timeout_o;

  int total = 0;
  int bad   = 0;
  logic [MW-1:0] sb [$];

  bp_me_cmd_router_ordered #(
    .num_targets_p     (2),
    .max_outstanding_p (4),
    .default_target_p  (1),
    .timeout_cycles_p  (8)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .route_base_i     (route_base_i),
    .route_mask_i     (route_mask_i),
    .mem_cmd_i        (mem_cmd_i),
    .mem_cmd_v_i      (mem_cmd_v_i),
    .mem_cmd_ready_o  (mem_cmd_ready_o),
    .mem_resp_o       (mem_resp_o),
    .mem_resp_v_o     (mem_resp_v_o),
    .mem_resp_ready_i (mem_resp_ready_i),
    .tgt_cmd_o        (tgt_cmd_o),
    .tgt_cmd_v_o      (tgt_cmd_v_o),
    .tgt_cmd_ready_i  (tgt_cmd_ready_i),
    .tgt_resp_i       (tgt_resp_i),
    .tgt_resp_v_i     (tgt_resp_v_i),
    .tgt_resp_yumi_o  (tgt_resp_yumi_o),
    .outstanding_o    (outstanding_o),
    .timeout_o        (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [MW-1:0] mk_cmd(input logic [AW-1:0] addr, input logic [63:0] data);
    return {data, 24'h0, addr};
  endfunction

  // A target answers with inverted data and the command header echoed.
  function automatic logic [MW-1:0] resp_of(input logic [MW-1:0] cmd);
    return {~cmd[127:64], cmd[63:0]};
  endfunction

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one command for a cycle; expect the given one-hot and ready.
  task automatic issue(input string name, input logic [MW-1:0] cmd,
                       input logic [NT-1:0] exp_v, input logic exp_rdy);
    mem_cmd_i   = cmd;
    mem_cmd_v_i = 1'b1;
    #1;
    check({name, "_tgt_v"}, MW'(tgt_cmd_v_o), MW'(exp_v));
    check({name, "_ready"}, MW'(mem_cmd_ready_o), MW'(exp_rdy));
    if (exp_rdy) sb.push_back(resp_of(cmd));
    tick();
    mem_cmd_v_i = 1'b0;
  endtask

  // Target t offers its response and waits (bounded) for the yumi.
  task automatic respond(input string name, input int t, input logic [MW-1:0] cmd);
    logic got;
    got = 1'b0;
    tgt_resp_i[t*MW +: MW] = resp_of(cmd);
    tgt_resp_v_i[t] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (tgt_resp_yumi_o[t]) got = 1'b1;
      @(posedge clk_i);
      #1;
    end
    tgt_resp_v_i[t] = 1'b0;
    check({name, "_yumi_seen"}, MW'(got), MW'(1'b1));
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    sb.delete();
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  // Scoreboard monitor: every forwarded response must match issue order.
  always @(negedge clk_i) begin
    if (!reset_i && mem_resp_v_o && mem_resp_ready_i) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL resp_unexpected: got=%0h required=none", mem_resp_o);
      end else begin
        check("resp_data", mem_resp_o, sb.pop_front());
      end
    end
  end

  logic [MW-1:0] c [5];

  initial begin
    reset_i          = 1'b1;
    route_base_i     = {40'h0, 40'h00_8000_0000};
    route_mask_i     = {40'h0, 40'h00_F800_0000};
    mem_cmd_i        = '0;
    mem_cmd_v_i      = 1'b1;
    mem_resp_ready_i = 1'b1;
    tgt_cmd_ready_i  = 2'b11;
    tgt_resp_i       = '0;
    tgt_resp_v_i     = '0;

    // Reset state with a command already pending on the master side.
    #3;
    check("rst_ready", MW'(mem_cmd_ready_o), MW'(0));
    check("rst_tgt_v", MW'(tgt_cmd_v_o), MW'(0));
    check("rst_outstanding", MW'(outstanding_o), MW'(0));
    check("rst_timeout", MW'(timeout_o), MW'(0));
    tick();
    mem_cmd_v_i = 1'b0;
    tick();
    reset_i = 1'b0;

    // Routing and in-order return.
    c[0] = mk_cmd(40'h00_8000_0040, 64'hA000_0000_0000_0001);
    c[1] = mk_cmd(40'h00_0030_0000, 64'hB000_0000_0000_0002);
    issue("route_t0", c[0], 2'b01, 1'b1);
    issue("route_t1", c[1], 2'b10, 1'b1);
    check("route_outstanding", MW'(outstanding_o), MW'(2));

    tgt_resp_i[1*MW +: MW] = resp_of(c[1]);
    tgt_resp_v_i[1] = 1'b1;
    #1;
    check("ord_hold_v", MW'(mem_resp_v_o), MW'(0));
    check("ord_hold_yumi", MW'(tgt_resp_yumi_o), MW'(0));
    tick();
    check("ord_hold_yumi2", MW'(tgt_resp_yumi_o), MW'(0));
    tgt_resp_i[0*MW +: MW] = resp_of(c[0]);
    tgt_resp_v_i[0] = 1'b1;
    #1;
    check("ord_t0_yumi", MW'(tgt_resp_yumi_o), MW'(2'b01));
    tick();
    tgt_resp_v_i[0] = 1'b0;
    #1;
    check("ord_outstanding1", MW'(outstanding_o), MW'(1));
    check("ord_t1_yumi", MW'(tgt_resp_yumi_o), MW'(2'b10));
    tick();
    tgt_resp_v_i[1] = 1'b0;
    #1;
    check("ord_outstanding0", MW'(outstanding_o), MW'(0));

    // Target backpressure blocks the master without enqueueing.
    tgt_cmd_ready_i = 2'b01;
    issue("bp_t1", mk_cmd(40'h00_0000_1000, 64'h1), 2'b10, 1'b0);
    check("bp_outstanding", MW'(outstanding_o), MW'(0));
    tgt_cmd_ready_i = 2'b11;

    // Full FIFO: no bypass on the dequeue cycle.
    for (int k = 0; k < 4; k++) begin
      c[k] = mk_cmd(40'h00_8000_0000 + 40'(k * 64), 64'hC000_0000_0000_0000 + 64'(k));
      issue("full_fill", c[k], 2'b01, 1'b1);
    end
    check("full_outstanding", MW'(outstanding_o), MW'(4));
    c[4] = mk_cmd(40'h00_0030_1000, 64'hD000_0000_0000_0005);
    mem_cmd_i   = c[4];
    mem_cmd_v_i = 1'b1;
    #1;
    check("full_ready", MW'(mem_cmd_ready_o), MW'(0));
    check("full_tgt_v", MW'(tgt_cmd_v_o), MW'(0));
    tick();
    tgt_resp_i[0*MW +: MW] = resp_of(c[0]);
    tgt_resp_v_i[0] = 1'b1;
    #1;
    check("full_deq_yumi", MW'(tgt_resp_yumi_o), MW'(2'b01));
    check("full_deq_ready", MW'(mem_cmd_ready_o), MW'(0));
    tick();
    tgt_resp_v_i[0] = 1'b0;
    #1;
    check("full_after_outstanding", MW'(outstanding_o), MW'(3));
    check("full_after_ready", MW'(mem_cmd_ready_o), MW'(1));
    check("full_after_tgt_v", MW'(tgt_cmd_v_o), MW'(2'b10));
    sb.push_back(resp_of(c[4]));
    tick();
    mem_cmd_v_i = 1'b0;
    check("full_refill", MW'(outstanding_o), MW'(4));
    respond("full_d1", 0, c[1]);
    respond("full_d2", 0, c[2]);
    respond("full_d3", 0, c[3]);
    respond("full_d4", 1, c[4]);
    check("full_drained", MW'(outstanding_o), MW'(0));

    // Timeout after eight stalled cycles, sticky past the response.
    do_reset();
    check("to_clear", MW'(timeout_o), MW'(0));
    c[0] = mk_cmd(40'h00_8000_0100, 64'hE000_0000_0000_0006);
    issue("to_cmd", c[0], 2'b01, 1'b1);
    for (int k = 0; k < 7; k++) tick();
    check("to_before", MW'(timeout_o), MW'(0));
    tick();
    check("to_set", MW'(timeout_o), MW'(1));
    respond("to_resp", 0, c[0]);
    check("to_sticky", MW'(timeout_o), MW'(1));
    check("to_outstanding", MW'(outstanding_o), MW'(0));

    // Asynchronous reset with three commands in flight.
    do_reset();
    issue("rm_a", mk_cmd(40'h00_8000_0200, 64'h7), 2'b01, 1'b1);
    issue("rm_b", mk_cmd(40'h00_0000_2000, 64'h8), 2'b10, 1'b1);
    issue("rm_c", mk_cmd(40'h00_8000_0240, 64'h9), 2'b01, 1'b1);
    check("rm_outstanding3", MW'(outstanding_o), MW'(3));
    mem_cmd_i   = mk_cmd(40'h00_8000_0280, 64'hA);
    mem_cmd_v_i = 1'b1;
    #3;
    reset_i = 1'b1;
    sb.delete();
    #1;
    check("rm_outstanding", MW'(outstanding_o), MW'(0));
    check("rm_timeout", MW'(timeout_o), MW'(0));
    check("rm_ready", MW'(mem_cmd_ready_o), MW'(0));
    check("rm_tgt_v", MW'(tgt_cmd_v_o), MW'(0));
    tgt_resp_i[0*MW +: MW] = mk_cmd(40'h00_8000_0200, 64'hDEAD);
    tgt_resp_v_i[0] = 1'b1;
    #1;
    check("rm_yumi_in_rst", MW'(tgt_resp_yumi_o), MW'(0));
    check("rm_resp_v", MW'(mem_resp_v_o), MW'(0));
    mem_cmd_v_i = 1'b0;
    tick();
    reset_i = 1'b0;
    #1;
    check("rm_yumi_after", MW'(tgt_resp_yumi_o), MW'(0));
    tgt_resp_v_i[0] = 1'b0;
    tick();
    check("rm_idle_outstanding", MW'(outstanding_o), MW'(0));

    check("sb_empty", MW'(sb.size()), MW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_me_cmd_router_ordered.md
Name: bp_me_cmd_router_ordered

Overview:
- N-target successor to the fixed mem/io command split in the softcore harness: routes bp_cce_mem_msg_s commands from one master port to num_targets_p slave ports by physical-address range.
- Records the target of every accepted command in an order FIFO and returns responses to the master strictly in issue order.
- Bounds outstanding requests and flags a response timeout.
- Sits between wrapper mem/io ports and bp_mem / bp_nonsynth_host / future devices.

Parameters:
- bp_params_p, e_bp_softcore_cfg, supplies paddr_width_p and cce_mem_msg_width_lp via declare_bp_me_if_widths
- num_targets_p, 2, number of slave ports (>=1)
- max_outstanding_p, 4, order FIFO depth (>=1)
- default_target_p, 1, target used when no address range matches (< num_targets_p)
- timeout_cycles_p, 1024, head-response wait limit; 0 disables timeout

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- route_base_i  in  num_targets_p*paddr_width_p  per-target base address, quasi-static
- route_mask_i  in  num_targets_p*paddr_width_p  per-target compare mask, quasi-static
- mem_cmd_i  in  cce_mem_msg_width_lp  master command
- mem_cmd_v_i  in  1  master command valid
- mem_cmd_ready_o  out  1  master command ready
- mem_resp_o  out  cce_mem_msg_width_lp  master response
- mem_resp_v_o  out  1  master response valid
- mem_resp_ready_i  in  1  master response ready
- tgt_cmd_o  out  cce_mem_msg_width_lp  broadcast command data
- tgt_cmd_v_o  out  num_targets_p  one-hot command valid
- tgt_cmd_ready_i  in  num_targets_p  per-target command ready
- tgt_resp_i  in  num_targets_p*cce_mem_msg_width_lp  per-target response
- tgt_resp_v_i  in  num_targets_p  per-target response valid
- tgt_resp_yumi_o  out  num_targets_p  per-target response consume
- outstanding_o  out  $clog2(max_outstanding_p+1)  accepted, unreturned commands
- timeout_o  out  1  sticky timeout flag

Behaviour:
- Reset is asynchronous and active-high.
  - Clears the order FIFO, outstanding count, timeout counter and timeout_o.
  - While reset_i is high, all valid, ready and yumi outputs are 0.
- Routing (combinational):
  - sel = lowest index i where (cmd.header.addr & mask[i]) == (base[i] & mask[i]); if none matches, sel = default_target_p.
  - A mask of 0 matches every address.
- Command path: zero latency, no buffering.
  - tgt_cmd_v_o[sel] = mem_cmd_v_i & ~fifo_full; all other bits are 0.
  - mem_cmd_ready_o = tgt_cmd_ready_i[sel] & ~fifo_full.
  - tgt_cmd_o = mem_cmd_i.
  - Accept = mem_cmd_v_i & mem_cmd_ready_o; on accept, sel is enqueued.
  - Full blocks new commands even if a dequeue happens in the same cycle (no bypass).
- Response path:
  - head = order FIFO head.
  - mem_resp_v_o = ~fifo_empty & tgt_resp_v_i[head]; mem_resp_o = tgt_resp_i[head].
  - tgt_resp_yumi_o[head] = mem_resp_v_o & mem_resp_ready_i; all other yumi bits are 0.
  - Yumi dequeues the head entry.
  - Responses from non-head targets stall in their sources.
  - When the FIFO is empty, no response is accepted or forwarded.
- Simultaneous enqueue and dequeue: outstanding_o is unchanged and FIFO pointers advance together. Both pointers wrap modulo max_outstanding_p.
- outstanding_o: +1 on accept only, -1 on yumi only; range 0..max_outstanding_p.
- Timeout:
  - The counter increments each cycle the FIFO is non-empty and no dequeue occurs.
  - It clears to 0 on dequeue or when the FIFO is empty, and saturates.
  - When it reaches timeout_cycles_p, timeout_o sets and stays 1 until reset.
  - Routing and ordering continue after a timeout.
- Reset mid-operation: outstanding state is discarded. Targets must be reset with the block; stale responses are never consumed while the FIFO is empty.
- Assertions (nonsynth): sel < num_targets_p; tgt_resp_v_i must be 0 for any target with no outstanding entry.

Decomposition:
- bp_me_pkg: router index width helper, and a route_entry_s typedef holding base and mask.
- Sub-module bp_me_order_fifo_async:
  - depth max_outstanding_p, width $clog2(num_targets_p) (min 1), asynchronous active-high reset.
  - Exposes full_o, empty_o, count_o.
  - Used here for the order FIFO; the timeout counter stays inline.

Test Plan:
- Two targets; route0 base 0x8000_0000, mask 0xF800_0000; route1 mask 0. Cmd addr 0x8000_0040 -> tgt_cmd_v_o=2'b01. Cmd addr 0x0030_0000 -> tgt_cmd_v_o=2'b10. outstanding_o reaches 2.
- Ordering: issue to T0 then T1; T1 responds first -> mem_resp_v_o stays 0 and T1 yumi stays 0. Then T0 responds -> T0 response forwarded, then T1 response; outstanding_o 2->1->0.
- Full: max_outstanding_p=4; issue 4 commands with no responses -> mem_cmd_ready_o=0 on the 5th. In the cycle of the first yumi, ready is still 0; ready becomes 1 on the next cycle.
- Backpressure: tgt_cmd_ready_i[1]=0 with a cmd to T1 -> mem_cmd_ready_o=0, tgt_cmd_v_o=2'b10, no enqueue.
- Timeout: timeout_cycles_p=8, one cmd, no response -> timeout_o rises after 8 non-dequeue cycles and stays 1 after the response returns.
- Reset: assert reset_i asynchronously with 3 outstanding -> outputs go to 0 immediately, outstanding_o=0, timeout_o=0, and a late T0 response is not yumi'd.
